alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//   Command-driven controller for the 3-port register RAM + ALU datapath. Accepts one
//   command per handshake, then drives the read addresses, ALU opcode/carry-in and
//   write-back in a fixed 4-state sequence. Keeps CARRY/BORROW/ZERO flags for chaining.
//   Sits between a host (test FSM or CPU decode) and the ram_word/alu pair, replacing C_IN mux.
// PARAMETERS
//   WIDTH   3  data word width (RAM word, ALU operands, immediate)
//   AWIDTH  2  register address width (RAM depth = 2**AWIDTH)
// PORTS
//   CLK          in   1       system clock; all state updates on rising edge
//   RST          in   1       synchronous, active-high reset
//   CMD_VALID    in   1       command present
//   CMD_READY    out  1       sequencer can accept (high only in IDLE, not in RST)
//   CMD_IMM      in   1       1: write CMD_DATA to CMD_C; 0: ALU op C <= A op B
//   CMD_OP       in   4       ALU instruction code (passed to ALU_INSTR)
//   CMD_CHAIN    in   1       1: ALU_CIN/ALU_BIN from stored flags; 0: forced 0
//   CMD_A/B/C    in   AWIDTH  source A, source B, destination register addresses
//   CMD_DATA     in   WIDTH   immediate value (used when CMD_IMM=1)
//   RAM_A_ADDR   out  AWIDTH  RAM port A address     RAM_A_DATA in WIDTH  port A read data
//   RAM_B_ADDR   out  AWIDTH  RAM port B address     RAM_B_DATA in WIDTH  port B read data
//   RAM_C_ADDR   out  AWIDTH  RAM write address      RAM_C_DATA out WIDTH write data
//   RAM_C_WE     out  1       write enable, active-high (integration inverts as needed)
//   ALU_INSTR    out  4       ALU opcode;  ALU_CIN / ALU_BIN out 1 carry/borrow in
//   ALU_OUT      in   WIDTH   ALU result;  ALU_COUT / ALU_BOUT in 1 carry/borrow out
//   CARRY_FLAG, BORROW_FLAG, ZERO_FLAG  out 1  status flags
//   BUSY         out  1       high in any state other than IDLE
//   DONE         out  1       one-cycle pulse the cycle after write-back
// BEHAVIOUR
//   - RAM reads combinational from address; RAM write occurs at clock edge ending a WE cycle.
//   - States: IDLE -> READ -> EXEC -> WRITE -> IDLE (ALU cmd); IDLE -> WRITE -> IDLE (IMM).
//   - Accept: CMD_VALID & CMD_READY at edge latches all CMD_* fields; VALID ignored otherwise.
//   - READ: RAM_A/B_ADDR = latched A/B, ALU_INSTR = latched OP, CIN/BIN per CHAIN.
//   - EXEC: same drive; at edge register ALU_OUT into result reg, COUT->CARRY_FLAG,
//     BOUT->BORROW_FLAG, ZERO_FLAG <= (ALU_OUT == 0).
//   - WRITE: RAM_C_ADDR = latched C, RAM_C_DATA = result (or CMD_DATA if IMM), RAM_C_WE=1.
//     IMM: ZERO_FLAG <= (CMD_DATA == 0); CARRY/BORROW unchanged.
//   - DONE pulses in the cycle after WRITE (i.e. first IDLE cycle); CMD_READY also high there.
//   - Latency accept->DONE: ALU cmd 4 cycles, IMM cmd 2 cycles. Max 1 cmd / 4 cycles.
//   - C equal to A or B: operands read before write; result uses old contents.
//   - Back-to-back cmds: next cmd reads value written by previous one (write done before READ).
//   - Arithmetic wraps modulo 2**WIDTH; overflow reported only via flags.
//   - RAM_C_WE gated combinationally by ~RST: no write in any cycle RST is high.
//   - Reset (any state, incl. mid-command): state=IDLE, flags=0, result=0, DONE=0, BUSY=0,
//     RAM_C_WE=0, all address/data/ALU_INSTR outputs=0, ALU_CIN/BIN=0; aborted cmd discarded.
//   - Idle outputs: addresses/data hold last driven value, RAM_C_WE=0.
// STRUCTURE
//   - Package alu_seq_pkg: state encoding (IDLE,READ,EXEC,WRITE, 2-bit localparams),
//     ALU opcode constants (ALU_OP_ADD = 4'h5, others as defined by alu), flag bit indices.
//   - Single module, no sub-modules; one FSM always block + command/result registers.
// TESTING (WIDTH=3, AWIDTH=2, RAM preloaded via IMM commands)
//   1. Reset, then IMM C=1 DATA=3 -> RAM_C_WE one cycle, reg1=3, DONE 2 cycles after accept.
//   2. ADD A=1(3) B=2(2) C=3 -> reg3=5, CARRY=0, ZERO=0, DONE at cycle 4.
//   3. ADD 6+3 C=0 -> reg0=1, CARRY=1; then ADD CHAIN 0+0 -> ALU_CIN=1, result 1.
//   4. ADD 4+4 -> result 0, ZERO=1, CARRY=1; C=A case: A=C=1 (3)+B(3) -> reg1=6.
//   5. CMD_VALID held through BUSY -> CMD_READY=0, second cmd accepted only in IDLE.
//   6. RST asserted in EXEC and in WRITE -> no RAM_C_WE, flags=0, IDLE next cycle.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module   : alu_seq_pkg
// Purpose  : Shared encodings for the ALU operation sequencer: FSM state codes,
//            ALU opcode constants and status-flag bit positions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  // FSM state codes (2-bit)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_READ  = ST_READ,
    S_EXEC  = ST_EXEC,
    S_WRITE = ST_WRITE
  } seq_state_t;

  // ALU opcodes; the sequencer passes opcodes through untouched, so only the
  // codes referenced by integration and test code are listed here.
  localparam logic [3:0] ALU_OP_ADD = 4'h5;

  // Bit positions inside the packed status-flag register
  localparam int FLAG_CARRY  = 0;
  localparam int FLAG_BORROW = 1;
  localparam int FLAG_ZERO   = 2;
  localparam int FLAG_W      = 3;

endpackage

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Command-driven controller for a 3-port register RAM + ALU pair.
//            Accepts one command per handshake and steps READ -> EXEC -> WRITE
//            (ALU command) or straight to WRITE (immediate command), keeping
//            carry/borrow/zero flags for chained arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int AWIDTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  // command interface
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_imm,
  input  logic [3:0]        cmd_op,
  input  logic              cmd_chain,
  input  logic [AWIDTH-1:0] cmd_a,
  input  logic [AWIDTH-1:0] cmd_b,
  input  logic [AWIDTH-1:0] cmd_c,
  input  logic [WIDTH-1:0]  cmd_data,
  // register RAM
  output logic [AWIDTH-1:0] ram_a_addr,
  input  logic [WIDTH-1:0]  ram_a_data,
  output logic [AWIDTH-1:0] ram_b_addr,
  input  logic [WIDTH-1:0]  ram_b_data,
  output logic [AWIDTH-1:0] ram_c_addr,
  output logic [WIDTH-1:0]  ram_c_data,
  output logic              ram_c_we,
  // ALU
  output logic [3:0]        alu_instr,
  output logic              alu_cin,
  output logic              alu_bin,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_cout,
  input  logic              alu_bout,
  // status
  output logic              carry_flag,
  output logic              borrow_flag,
  output logic              zero_flag,
  output logic              busy,
  output logic              done
);

  seq_state_t        r_state;
  seq_state_t        w_next_state;
  logic              w_accept;

  logic              r_imm;
  logic [3:0]        r_op;
  logic              r_chain;
  logic [AWIDTH-1:0] r_a;
  logic [AWIDTH-1:0] r_b;
  logic [AWIDTH-1:0] r_c;
  logic [WIDTH-1:0]  r_data;
  logic [WIDTH-1:0]  r_result;
  logic [FLAG_W-1:0] r_flags;
  logic              r_done;

  // Operand data flows directly from the RAM read ports into the ALU; the
  // sequencer only owns the addresses, so these inputs carry no logic here.
  logic              w_unused_rd;
  assign w_unused_rd = ^{ram_a_data, ram_b_data};

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode and handshake qualification
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept     = 1'b1;
          w_next_state = cmd_imm ? S_WRITE : S_READ;
        end
      end
      S_READ:  w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_WRITE;
      S_WRITE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Command latch: all fields captured together on an accepted handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_imm   <= 1'b0;
      r_op    <= '0;
      r_chain <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_data  <= '0;
    end else if (w_accept) begin
      r_imm   <= cmd_imm;
      r_op    <= cmd_op;
      r_chain <= cmd_chain;
      r_a     <= cmd_a;
      r_b     <= cmd_b;
      r_c     <= cmd_c;
      r_data  <= cmd_data;
    end
  end

  // Result and flags: ALU outputs captured at the end of EXEC; an immediate
  // write only refreshes ZERO so carry/borrow chains survive register loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_flags  <= '0;
    end else if (r_state == S_EXEC) begin
      r_result              <= alu_out;
      r_flags[FLAG_CARRY]   <= alu_cout;
      r_flags[FLAG_BORROW]  <= alu_bout;
      r_flags[FLAG_ZERO]    <= (alu_out == '0);
    end else if ((r_state == S_WRITE) && r_imm) begin
      r_flags[FLAG_ZERO]    <= (r_data == '0);
    end
  end

  // DONE marks the first IDLE cycle after a write-back
  always_ff @(posedge clk) begin
    if (rst) r_done <= 1'b0;
    else     r_done <= (r_state == S_WRITE);
  end

  // Addresses and data come straight from the latched command, so they hold
  // their last value while idle and read as zero after reset.
  assign ram_a_addr  = r_a;
  assign ram_b_addr  = r_b;
  assign ram_c_addr  = r_c;
  assign ram_c_data  = r_imm ? r_data : r_result;
  assign alu_instr   = r_op;
  assign alu_cin     = r_chain & r_flags[FLAG_CARRY];
  assign alu_bin     = r_chain & r_flags[FLAG_BORROW];

  // Write strobe and ready are masked by reset within the same cycle
  assign ram_c_we    = (r_state == S_WRITE) & ~rst;
  assign cmd_ready   = (r_state == S_IDLE) & ~rst;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;

  assign carry_flag  = r_flags[FLAG_CARRY];
  assign borrow_flag = r_flags[FLAG_BORROW];
  assign zero_flag   = r_flags[FLAG_ZERO];

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module   : tb_alu_op_sequencer
// Purpose  : Self-checking bench for alu_op_sequencer with a behavioural
//            register RAM and ALU; table-driven commands plus hand-written
//            busy-hold and mid-command reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int WIDTH  = 3;
  localparam int AWIDTH = 2;
  localparam logic [3:0] OP_SUB = 4'h6;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_imm, cmd_chain;
  logic [3:0]        cmd_op;
  logic [AWIDTH-1:0] cmd_a, cmd_b, cmd_c;
  logic [WIDTH-1:0]  cmd_data;
  logic [AWIDTH-1:0] ram_a_addr, ram_b_addr, ram_c_addr;
  logic [WIDTH-1:0]  ram_a_data, ram_b_data, ram_c_data;
  logic              ram_c_we;
  logic [3:0]        alu_instr;
  logic              alu_cin, alu_bin, alu_cout, alu_bout;
  logic [WIDTH-1:0]  alu_out;
  logic              carry_flag, borrow_flag, zero_flag, busy, done;

  alu_op_sequencer #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_imm(cmd_imm),
    .cmd_op(cmd_op), .cmd_chain(cmd_chain), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_c(cmd_c), .cmd_data(cmd_data),
    .ram_a_addr(ram_a_addr), .ram_a_data(ram_a_data),
    .ram_b_addr(ram_b_addr), .ram_b_data(ram_b_data),
    .ram_c_addr(ram_c_addr), .ram_c_data(ram_c_data), .ram_c_we(ram_c_we),
    .alu_instr(alu_instr), .alu_cin(alu_cin), .alu_bin(alu_bin),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_bout(alu_bout),
    .carry_flag(carry_flag), .borrow_flag(borrow_flag), .zero_flag(zero_flag),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural register RAM: combinational reads, write on the clock edge
  logic [WIDTH-1:0] mem [4];
  assign ram_a_data = mem[ram_a_addr];
  assign ram_b_data = mem[ram_b_addr];
  always @(posedge clk) if (ram_c_we) mem[ram_c_addr] <= ram_c_data;

  // Behavioural ALU: ADD with carry, SUB with borrow, otherwise pass A
  logic [WIDTH:0] alu_t;
  always_comb begin
    alu_t    = '0;
    alu_out  = ram_a_data;
    alu_cout = 1'b0;
    alu_bout = 1'b0;
    if (alu_instr == ALU_OP_ADD) begin
      alu_t    = {1'b0, ram_a_data} + {1'b0, ram_b_data} + {{WIDTH{1'b0}}, alu_cin};
      alu_out  = alu_t[WIDTH-1:0];
      alu_cout = alu_t[WIDTH];
    end else if (alu_instr == OP_SUB) begin
      alu_t    = {1'b0, ram_a_data} - {1'b0, ram_b_data} - {{WIDTH{1'b0}}, alu_bin};
      alu_out  = alu_t[WIDTH-1:0];
      alu_bout = alu_t[WIDTH];
    end
  end

  typedef struct packed {
    logic        imm;
    logic [3:0]  op;
    logic        chain;
    logic [1:0]  a, b, c;
    logic [2:0]  data;
    logic [2:0]  exp_data;
    logic        exp_carry, exp_borrow, exp_zero, exp_cin, exp_bin;
  } vec_t;

  function automatic vec_t mk(input logic imm, input logic [3:0] op, input logic chain,
                              input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                              input logic [2:0] data, input logic [2:0] ed,
                              input logic ec, input logic eb, input logic ez,
                              input logic ecin, input logic ebin);
    vec_t v;
    v.imm = imm; v.op = op; v.chain = chain; v.a = a; v.b = b; v.c = c; v.data = data;
    v.exp_data = ed; v.exp_carry = ec; v.exp_borrow = eb; v.exp_zero = ez;
    v.exp_cin = ecin; v.exp_bin = ebin;
    return v;
  endfunction

  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Scoreboard monitor: a write pops the oldest expectation; the following
  // DONE cycle confirms the flags for that command.
  vec_t cur;
  bit   pend = 1'b0;
  always @(negedge clk) begin
    if (ram_c_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write_we", ram_c_we, 0);
      end else begin
        cur = sb.pop_front();
        check("wb_addr", ram_c_addr, cur.c);
        check("wb_data", ram_c_data, cur.exp_data);
        pend = 1'b1;
      end
    end else if (done === 1'b1 && pend) begin
      check("carry_flag", carry_flag, cur.exp_carry);
      check("borrow_flag", borrow_flag, cur.exp_borrow);
      check("zero_flag", zero_flag, cur.exp_zero);
      pend = 1'b0;
    end
  end

  task automatic set_fields(input vec_t v);
    cmd_imm = v.imm; cmd_op = v.op; cmd_chain = v.chain;
    cmd_a = v.a; cmd_b = v.b; cmd_c = v.c; cmd_data = v.data;
  endtask

  // Wait for ready, present a command, return #1 after the accepting edge
  task automatic drive_cmd(input vec_t v, input bit expect_wb);
    int n;
    n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("ready_before_accept", cmd_ready, 1);
    set_fields(v);
    cmd_valid = 1'b1;
    if (expect_wb) sb.push_back(v);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send(input vec_t v);
    int lat;
    drive_cmd(v, 1'b1);
    if (!v.imm) begin
      check("read_busy", busy, 1);
      check("read_instr", alu_instr, v.op);
      check("read_a_addr", ram_a_addr, v.a);
      check("read_b_addr", ram_b_addr, v.b);
      check("read_cin", alu_cin, v.exp_cin);
      check("read_bin", alu_bin, v.exp_bin);
    end
    lat = 1;
    while (done !== 1'b1 && lat < 12) begin @(posedge clk); #1; lat++; end
    check("latency", lat, v.imm ? 2 : 4);
  endtask

  // Run a command and reset it in EXEC (extra=0) or WRITE (extra=1)
  task automatic abort_cmd(input vec_t v, input int extra);
    drive_cmd(v, 1'b0);
    @(posedge clk); #1;
    for (int k = 0; k < extra; k++) begin @(posedge clk); #1; end
    if (extra > 0) check("abort_in_write_busy", busy, 1);
    rst = 1'b1; #1;
    check("abort_we_masked", ram_c_we, 0);
    check("abort_ready_masked", cmd_ready, 0);
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_carry", carry_flag, 0);
    check("abort_borrow", borrow_flag, 0);
    check("abort_zero", zero_flag, 0);
    check("abort_done", done, 0);
    check("abort_we", ram_c_we, 0);
    check("abort_c_addr", ram_c_addr, 0);
    check("abort_instr", alu_instr, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_abort_done", done, 0);
    check("post_abort_ready", cmd_ready, 1);
    check("post_abort_reg3", mem[3], 5);
  endtask

  vec_t tbl[13];
  vec_t vx, vy;
  int   w;

  initial begin
    // imm op ch a b c data | data carry borrow zero cin bin
    tbl[0]  = mk(1, 4'h0,       0, 0, 0, 1, 3,  3, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 4'h0,       0, 0, 0, 2, 2,  2, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, ALU_OP_ADD, 0, 1, 2, 3, 0,  5, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 4'h0,       0, 0, 0, 0, 6,  6, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, ALU_OP_ADD, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0);
    tbl[5]  = mk(1, 4'h0,       0, 0, 0, 2, 0,  0, 1, 0, 1, 0, 0);
    tbl[6]  = mk(0, ALU_OP_ADD, 1, 2, 2, 3, 0,  1, 0, 0, 0, 1, 0);
    tbl[7]  = mk(1, 4'h0,       0, 0, 0, 2, 4,  4, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, ALU_OP_ADD, 0, 2, 2, 3, 0,  0, 1, 0, 1, 0, 0);
    tbl[9]  = mk(0, ALU_OP_ADD, 0, 1, 1, 1, 0,  6, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, OP_SUB,     0, 0, 1, 2, 0,  3, 0, 1, 0, 0, 0);
    tbl[11] = mk(0, OP_SUB,     1, 2, 0, 0, 0,  1, 0, 0, 0, 0, 1);
    tbl[12] = mk(1, 4'h0,       0, 0, 0, 3, 0,  0, 0, 0, 1, 0, 0);

    rst = 1'b1; cmd_valid = 1'b0;
    set_fields(tbl[0]);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", ram_c_we, 0);
    check("rst_flags", {carry_flag, borrow_flag, zero_flag}, 0);
    check("rst_c_addr", ram_c_addr, 0);
    check("rst_c_data", ram_c_data, 0);
    check("rst_instr", alu_instr, 0);
    check("rst_cin_bin", {alu_cin, alu_bin}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", cmd_ready, 1);

    for (int i = 0; i < 13; i++) send(tbl[i]);

    // Valid held through BUSY; fields switched after accept must not be
    // picked up until the sequencer is back in IDLE.
    vx = mk(0, ALU_OP_ADD, 0, 1, 1, 2, 0, 4, 1, 0, 0, 0, 0);
    vy = mk(1, 4'h0,       0, 0, 0, 3, 5, 5, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("hold_ready_first", cmd_ready, 1);
    set_fields(vx); cmd_valid = 1'b1; sb.push_back(vx);
    @(posedge clk); #1;
    set_fields(vy); sb.push_back(vy);
    for (int k = 1; k <= 3; k++) begin
      check("hold_ready_busy", cmd_ready, 0);
      @(posedge clk); #1;
    end
    check("hold_done", done, 1);
    check("hold_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("hold_second_busy", busy, 1);
    w = 0;
    while (done !== 1'b1 && w < 10) begin @(posedge clk); #1; w++; end
    check("hold_second_done", done, 1);

    abort_cmd(mk(0, ALU_OP_ADD, 0, 0, 1, 3, 0, 7, 0, 0, 0, 0, 0), 0);
    abort_cmd(mk(0, ALU_OP_ADD, 0, 1, 1, 3, 0, 4, 1, 0, 0, 0, 0), 1);

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    check("final_reg2", mem[2], 4);
    check("final_reg0", mem[0], 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
